// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle N-bit adder/subtractor, W bits per clock, LSB chunk first
module seq_add_sub #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Ovf
);
    localparam int C = N / W;
    localparam int CW = C > 1 ? $clog2(C) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0] a_w, b_w, s_w, s_sh;
    logic [W:0] csum;
    logic carry, last, cmsb;
    // operands shift right each cycle so the live chunk is always bits W-1:0
    assign csum = {1'b0, a_w[W-1:0]} + {1'b0, b_w[W-1:0]} + {{W{1'b0}}, carry};
    assign s_sh = (s_w >> W) | (N'(csum[W-1:0]) << (N - W));
    assign cmsb = a_w[W-1] ^ b_w[W-1] ^ csum[W-1];
    assign last = cnt == CW'(C - 1);
    always_comb begin
        nxt  = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
        busy = state == RUN;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_w   <= '0;
            b_w   <= '0;
            s_w   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            state <= nxt;
            if (state != RUN && start) begin
                a_w   <= A;
                b_w   <= mode ? ~B : B;
                carry <= Cin ^ mode;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_w   <= a_w >> W;
                b_w   <= b_w >> W;
                s_w   <= s_sh;
                carry <= csum[W];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    Sum  <= s_sh;
                    Cout <= csum[W];
                    Ovf  <= cmsb ^ csum[W];
                end
            end
        end
    end
endmodule

// File: doc/seq_add_sub.md
Name: seq_add_sub

Overview:
Parametrised multi-cycle N-bit adder/subtractor with carry/borrow-in, carry-out and signed-overflow flags. Processes W bits per clock, LSB chunk first, so operand width can grow without growing the carry chain. Uses a start/busy/done handshake. It is the sequential, mode-selectable successor to the team's combinational N-bit adder.

Parameters:
N, 8, operand/result width in bits
W, 2, bits processed per cycle; N must be divisible by W (1 <= W <= N)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request operation; sampled only in IDLE or DONE
mode  input  1  0 = add (A+B+Cin), 1 = subtract (A-B-Cin)
A  input  N  operand A, captured when start accepted
B  input  N  operand B, captured when start accepted
Cin  input  1  carry-in (add) / borrow-in (sub), captured with operands
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: Sum/Cout/Ovf just updated
Sum  output  N  result, held until next completion
Cout  output  1  add: carry out; sub: 1 = no borrow, 0 = borrow
Ovf  output  1  two's-complement signed overflow of the result

Behaviour:
- States: IDLE, RUN, DONE. Chunk counter counts 0..N/W-1.
- Reset (rst=1 at an edge): state IDLE, counter 0, busy=0, done=0, Sum=0, Cout=0, Ovf=0. Reset overrides all other inputs. Reset during RUN aborts the operation; no done pulse.
- Accept: at edge k, if state is IDLE or DONE and start=1:
  - Latch A into a working register, and B (add) or ~B (sub) into a working register.
  - Carry register = Cin (add) or ~Cin (sub).
  - Counter = 0, state = RUN.
- start is ignored while in RUN; no queuing.
- RUN: each edge k+1..k+N/W processes one W-bit chunk i (bits i*W+W-1 : i*W):
  - chunk sum = Achunk + Bchunk + carry, (W+1)-bit.
  - Low W bits are written into the working sum; the carry register takes bit W.
  - On the last chunk, the carry into bit N-1 is also captured.
- Completion, at edge k+N/W (last chunk):
  - Sum = full working sum.
  - Cout = final carry.
  - Ovf = carry into MSB XOR carry out of MSB.
  - State = DONE, done=1, busy=0.
- Latency: done is high in the cycle after edge k+N/W, i.e. N/W cycles after acceptance.
- Sum, Cout and Ovf hold their old values during RUN and change only at completion.
- DONE lasts one cycle, then goes to IDLE (start=0) or straight to RUN (start=1, back-to-back acceptance; done pulses still separate).
- busy=1 exactly in RUN; done=1 exactly in DONE.
- W=N degenerates to a single RUN cycle; the behaviour is otherwise identical.
- A/B/Cin/mode changes after acceptance have no effect on the operation in flight.

Test Plan:
1. N=8, W=2, mode=0, A=20, B=40, Cin=1, pulse start -> busy for 4 cycles; done pulse; Sum=61, Cout=0, Ovf=0.
2. mode=0, A=200, B=100, Cin=0 -> Sum=44, Cout=1, Ovf=0. Then A=100, B=50 -> Sum=150 (0x96), Cout=0, Ovf=1.
3. mode=1, A=20, B=40, Cin=0 -> Sum=236 (-20), Cout=0, Ovf=0. Then A=40, B=20, Cin=1 -> Sum=19, Cout=1. Then A=0x80, B=1, Cin=0 -> Sum=0x7F, Cout=1, Ovf=1.
4. Hold start=1 continuously with changing operands -> start re-sampled only in DONE; done pulses every 5 cycles. Mid-RUN start and operand changes are ignored; results match the operands latched at acceptance.
5. Assert rst at the 2nd RUN cycle -> next cycle busy=0, done=0, Sum=0, Cout=0, Ovf=0; no done pulse afterwards. A new start then completes normally.
6. Re-run scenarios 1-3 with N=16/W=4 and N=8/W=8 -> same arithmetic against a reference model; latency 4 and 1 cycles respectively.
